seg7_scan_ctrl: RTL
===================

# seg7_scan_ctrl

Time-multiplexed scan controller for a 4-digit common-anode 7-segment display. It shares one hex-to-segment decode path among four digits and walks a digit-select counter through them. A blanking gap between digits suppresses ghosting. New display values are accepted by a load handshake and applied only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
- ON_CYCLES, 1000, clocks each digit is lit per slot (>=1)
- BLANK_CYCLES, 16, clocks of all-off gap before each digit (>=1)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- value_in  in  16  four hex nibbles; [3:0] = digit 0 (rightmost) … [15:12] = digit 3
- dp_in  in  4  decimal point per digit, 1 = lit; bit n = digit n
- load  in  1  level; each high cycle stages value_in/dp_in
- enable  in  1  1 = scan, 0 = go idle at next frame boundary
- led_out  out  8  registered, active-low segments: [7:1] = a..g, [0] = dp
- digit_sel  out  4  registered, active-low one-hot anode select; bit n = digit n
- load_ack  out  1  one-cycle pulse: staged data now displayed
- frame_done  out  1  one-cycle pulse at end of each digit-3 slot

## Operation
- Glyphs (before dp), active-low: 0=00000011, 1=10011111, 2=00100101, 3=00001101, 4=10011001, 5=01001001, 6=01000001, 7=00011111, 8=00000001, 9=00001001, A=00010001, b=11000001, c=11100101, d=10000101, E=01100001, F=01110001. If the digit's dp bit is 1, clear bit 0.
- The block has three registers:
  - staging: 16-bit value + 4-bit dp + pending flag.
  - display: 16-bit value + 4-bit dp.
  - sequencer: state, 2-bit idx, cycle counter.
- Any edge with load=1 writes value_in/dp_in to staging and sets pending. The latest load wins.
- States:
  - IDLE: outputs off (led_out=8'hFF, digit_sel=4'hF). If pending, copy staging to display on the next edge, pulse load_ack, clear pending. If enable=1, go to BLANK with idx=0, cnt=0.
  - BLANK: outputs off for BLANK_CYCLES clocks, then go to SHOW with cnt=0.
  - SHOW: digit_sel bit idx=0, led_out = glyph(display nibble idx, dp idx) for ON_CYCLES clocks.
    - End of slot with idx<3: idx+1, go to BLANK.
    - End of slot with idx=3 (frame boundary): pulse frame_done. If pending, copy staging to display, pulse load_ack in the same cycle as frame_done, clear pending. Then idx=0; go to BLANK if enable=1, else IDLE.
- A load on the same edge as the frame-boundary copy: the old staged data is copied, the new data is staged, and pending stays set.
- Dropping enable mid-frame has no effect until the frame boundary; the frame completes.
- Counter width is ceil(log2(max(ON_CYCLES, BLANK_CYCLES))). idx wraps 3 to 0.

## Timing
- Reset values: state=IDLE, idx=0, cnt=0, staging=display=0, pending=0, led_out=8'hFF, digit_sel=4'hF, load_ack=0, frame_done=0.
- Reset takes effect immediately, with no clock, including mid-SHOW.
- Outputs are registered and update on the same edge as the state change.
- Entering from IDLE: enable=1 at edge E gives the first BLANK cycle after E. digit 0 lights after edge E+BLANK_CYCLES.
- Frame period = 4*(BLANK_CYCLES+ON_CYCLES) clocks. frame_done is high in the cycle after the final SHOW cycle of digit 3.
- Load-to-display latency:
  - In IDLE: 1 edge.
  - While scanning: up to one frame. The value is visible from the next digit-0 SHOW.
- digit_sel never has more than one bit low. It is never low in the same cycle as a different digit's segments.

## Test plan
All scenarios use ON_CYCLES=3, BLANK_CYCLES=2.
- Reset: assert rst_n=0 mid-SHOW without a clock -> led_out=8'hFF, digit_sel=4'hF, load_ack=0, frame_done=0 immediately.
- IDLE load and scan: enable=0, load 1 cycle with value_in=16'h3210, dp_in=0 -> load_ack next cycle. Then enable=1 -> repeating 2 off cycles followed by 3 lit cycles per digit:
  - digit_sel 4'b1110 / led_out 8'b00000011
  - digit_sel 4'b1101 / led_out 8'b10011111
  - digit_sel 4'b1011 / led_out 8'b00100101
  - digit_sel 4'b0111 / led_out 8'b00001101
  - frame_done pulses 20 cycles after the first BLANK.
- Mid-frame load: during digit 1, load 16'hFEDC -> rest of the frame is unchanged. load_ack and frame_done pulse together. The next digit 0 shows 8'b11100101 (c).
- Back-to-back loads: 16'h1111, then 16'h8888 with dp_in=4'b0001, in one frame -> one load_ack; digit 0 shows 8'b00000000.
- Enable drop: enable=0 during digit 2 -> digits 2 and 3 complete, frame_done pulses, then steady idle outputs (8'hFF, 4'hF).
- Simultaneous load and boundary: load 16'hAAAA on the boundary edge while 16'h5555 is pending -> 5555 is shown next frame. AAAA is shown the frame after, with a second load_ack.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Four-digit common-anode 7-segment scan controller with a blanking gap between
// digits and frame-aligned updates of the displayed value.
module seg7_scan_ctrl #(
  parameter int ON_CYCLES    = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        enable,
  output logic [7:0]  led_out,
  output logic [3:0]  digit_sel,
  output logic        load_ack,
  output logic        frame_done
);

  localparam int MAX_CYC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [1:0]       idx_reg, idx_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [15:0]      stage_val_reg, stage_val_next;
  logic [3:0]       stage_dp_reg, stage_dp_next;
  logic             pending_reg, pending_next;
  logic [15:0]      disp_val_reg, disp_val_next;
  logic [3:0]       disp_dp_reg, disp_dp_next;
  logic [7:0]       led_reg, led_next;
  logic [3:0]       sel_reg, sel_next;
  logic             load_ack_reg, load_ack_next;
  logic             frame_done_reg, frame_done_next;
  logic             copy;

  // Active-low segment pattern, bits [7:1] = a..g, bit 0 = decimal point.
  function automatic logic [7:0] glyph(input logic [3:0] nib, input logic dp);
    logic [7:0] g;
    g = 8'hFF;
    case (nib)
      4'h0: g = 8'b00000011;
      4'h1: g = 8'b10011111;
      4'h2: g = 8'b00100101;
      4'h3: g = 8'b00001101;
      4'h4: g = 8'b10011001;
      4'h5: g = 8'b01001001;
      4'h6: g = 8'b01000001;
      4'h7: g = 8'b00011111;
      4'h8: g = 8'b00000001;
      4'h9: g = 8'b00001001;
      4'hA: g = 8'b00010001;
      4'hB: g = 8'b11000001;
      4'hC: g = 8'b11100101;
      4'hD: g = 8'b10000101;
      4'hE: g = 8'b01100001;
      4'hF: g = 8'b01110001;
      default: g = 8'hFF;
    endcase
    if (dp) g[0] = 1'b0;
    return g;
  endfunction

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    cnt_next        = cnt_reg;
    stage_val_next  = stage_val_reg;
    stage_dp_next   = stage_dp_reg;
    pending_next    = pending_reg;
    disp_val_next   = disp_val_reg;
    disp_dp_next    = disp_dp_reg;
    load_ack_next   = 1'b0;
    frame_done_next = 1'b0;
    copy            = 1'b0;
    led_next        = 8'hFF;
    sel_next        = 4'hF;

    case (state_reg)
      ST_IDLE: begin
        copy = pending_reg;
        if (enable) begin
          state_next = ST_BLANK;
          idx_next   = 2'd0;
          cnt_next   = '0;
        end
      end
      ST_BLANK: begin
        if (cnt_reg == BLANK_LAST) begin
          state_next = ST_SHOW;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_SHOW: begin
        if (cnt_reg == ON_LAST) begin
          cnt_next = '0;
          if (idx_reg == 2'd3) begin
            // Frame boundary: the only point where display data may change.
            frame_done_next = 1'b1;
            copy            = pending_reg;
            idx_next        = 2'd0;
            state_next      = enable ? ST_BLANK : ST_IDLE;
          end else begin
            idx_next   = idx_reg + 2'd1;
            state_next = ST_BLANK;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (copy) begin
      disp_val_next = stage_val_reg;
      disp_dp_next  = stage_dp_reg;
      load_ack_next = 1'b1;
      pending_next  = 1'b0;
    end
    // A load on a copy edge restages after the old data has been taken.
    if (load) begin
      stage_val_next = value_in;
      stage_dp_next  = dp_in;
      pending_next   = 1'b1;
    end

    if (state_next == ST_SHOW) begin
      led_next = glyph(disp_val_reg[{idx_next, 2'b00} +: 4], disp_dp_reg[idx_next]);
      sel_next = ~(4'b0001 << idx_next);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= 2'd0;
      cnt_reg        <= '0;
      stage_val_reg  <= 16'h0000;
      stage_dp_reg   <= 4'h0;
      pending_reg    <= 1'b0;
      disp_val_reg   <= 16'h0000;
      disp_dp_reg    <= 4'h0;
      led_reg        <= 8'hFF;
      sel_reg        <= 4'hF;
      load_ack_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      cnt_reg        <= cnt_next;
      stage_val_reg  <= stage_val_next;
      stage_dp_reg   <= stage_dp_next;
      pending_reg    <= pending_next;
      disp_val_reg   <= disp_val_next;
      disp_dp_reg    <= disp_dp_next;
      led_reg        <= led_next;
      sel_reg        <= sel_next;
      load_ack_reg   <= load_ack_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign led_out    = led_reg;
  assign digit_sel  = sel_reg;
  assign load_ack   = load_ack_reg;
  assign frame_done = frame_done_reg;

endmodule
